// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/RUN/DRAIN control, one-cycle-latency instruction RAM, in-order {inst, pc} buffer.
// Define FETCH_SKID_BUFFER_EN for a 2-entry buffer (1 inst/cycle); otherwise the buffer holds 1 entry.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] start_pc,
    input  logic        stop,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] inst_ram_address,
    output logic        inst_ram_read,
    input  logic [31:0] inst_ram_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [15:0] out_pc,
    output logic        busy
);

`ifdef FETCH_SKID_BUFFER_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [15:0] pc;
    } entry_t;

    state_t          state;
    logic [15:0]     fetch_pc;
    logic [15:0]     inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    entry_t          buf_q [DEPTH];

    logic            pop;
    logic            push;
    logic            flush;
    logic [CW-1:0]   wr_idx;
    logic [CW-1:0]   count_next;

    // NOTE: every signal assigned in always_comb is given a value on every path, so no latch is inferred.
    always_comb begin
        out_valid  = (count != '0);
        pop        = out_valid && out_ready;
        flush      = (state == RUN) && redirect;
        push       = inflight && !flush;
        wr_idx     = count - CW'(pop);
        count_next = wr_idx + CW'(push);
        // Only issue when the returning word is guaranteed a free slot.
        inst_ram_read = (state == RUN) && !stop && !redirect
                        && ((int'(count) - int'(pop) + int'(inflight)) < DEPTH);
        inst_ram_address = fetch_pc;
        out_inst = out_valid ? buf_q[0].inst : '0;
        out_pc   = out_valid ? buf_q[0].pc   : '0;
        busy     = (state != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            count       <= '0;
        end else begin
            inflight <= inst_ram_read;
            if (inst_ram_read) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 16'd1;
            end
            count <= flush ? '0 : count_next;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        fetch_pc <= start_pc;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        state    <= stop ? IDLE : RUN;
                    end else if (stop) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_next == '0 && !inflight)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: payload storage has no reset; count qualifies it and out_* are masked while empty.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && i == int'(wr_idx))
                buf_q[i] <= '{inst: inst_ram_data, pc: inflight_pc};
            else if (pop && i < DEPTH - 1)
                buf_q[i] <= buf_q[(i + 1) % DEPTH];
        end
    end

endmodule
